persiana_motor_driver: RTL and testbench

//   Downstream of the blind FSM: turns its subir/bajar commands into safe motor

---
 rtl/persiana_motor_driver_if.sv | 32 +++
 rtl/persiana_motor_driver.sv | 158 +++++++++++++++
 tb/tb_persiana_motor_driver.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/persiana_motor_driver_if.sv
// persiana_motor_driver_if
//   Groups the command, end-switch and motor-drive signals between the blind
//   FSM side (master) and the motor driver (slave).
//   Signals:
//     subir, bajar   raise / lower command levels from the blind FSM
//     Ssup, Sinf     top / bottom end switches (1 = end reached)
//     fault_clr      clears a latched run-timeout fault
//     motor_en       motor energised
//     motor_dir      1 = up, 0 = down (meaningful while motor_en = 1)
//     fault          sticky run-timeout fault
//     busy           driver is not idle
interface persiana_motor_driver_if;
    logic subir;
    logic bajar;
    logic Ssup;
    logic Sinf;
    logic fault_clr;
    logic motor_en;
    logic motor_dir;
    logic fault;
    logic busy;

    modport master (
        output subir, bajar, Ssup, Sinf, fault_clr,
        input  motor_en, motor_dir, fault, busy
    );

    modport slave (
        input  subir, bajar, Ssup, Sinf, fault_clr,
        output motor_en, motor_dir, fault, busy
    );
endinterface

// File: rtl/persiana_motor_driver.sv
// persiana_motor_driver
//   Converts subir/bajar commands into safe motor drive. Every start is
//   preceded by DEAD_T motor-off cycles with the direction already settled,
//   and every stop is followed by DEAD_T motor-off cycles, so the direction
//   never changes while the motor is energised. End switches stop the motor
//   immediately; a run longer than MAX_RUN cycles latches a fault that only
//   fault_clr releases.
//   Ports:
//     Reloj   in  clock, rising edge
//     reset   in  asynchronous active-low reset
//     bus     slave side of persiana_motor_driver_if (commands, switches,
//             fault_clr in; motor_en, motor_dir, fault, busy out)
//   All outputs are registered and decoded from the next state.
module persiana_motor_driver #(
    parameter int DEAD_T  = 8,
    parameter int MAX_RUN = 1024,
    parameter int TW      = 11
) (
    input  logic                     Reloj,
    input  logic                     reset,
    persiana_motor_driver_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DEAD  = 3'd1,
        RUN   = 3'd2,
        BRAKE = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic [TW-1:0] DEAD_LAST = TW'(DEAD_T - 1);
    localparam logic [TW-1:0] RUN_LAST  = TW'(MAX_RUN - 1);
    localparam logic [TW-1:0] CNT_MAX   = '1;

    state_t        state, state_nx;
    logic          tgt, tgt_nx;
    logic [TW-1:0] dcnt, dcnt_nx;
    logic [TW-1:0] rcnt, rcnt_nx;

    logic motor_en_q, motor_dir_q, fault_q, busy_q;
    logic motor_en_nx, motor_dir_nx, fault_nx, busy_nx;

    logic up_req, dn_req, tgt_req;

    // Counters hold at all-ones instead of wrapping.
    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (v == CNT_MAX) ? v : v + TW'(1);
    endfunction

    // subir and bajar together cancel each other out; an end switch in the
    // requested direction removes the request.
    assign up_req  = bus.subir & ~bus.bajar & ~bus.Ssup;
    assign dn_req  = bus.bajar & ~bus.subir & ~bus.Sinf;
    assign tgt_req = tgt ? up_req : dn_req;

    // NOTE: every always_comb target gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        tgt_nx   = tgt;
        dcnt_nx  = dcnt;
        rcnt_nx  = rcnt;

        unique case (state)
            IDLE: begin
                if (up_req) begin
                    state_nx = DEAD;
                    tgt_nx   = 1'b1;
                    dcnt_nx  = '0;
                end else if (dn_req) begin
                    state_nx = DEAD;
                    tgt_nx   = 1'b0;
                    dcnt_nx  = '0;
                end
            end
            DEAD: begin
                if (!tgt_req) begin
                    state_nx = IDLE;
                end else if (dcnt == DEAD_LAST) begin
                    state_nx = RUN;
                    rcnt_nx  = '0;
                end else begin
                    dcnt_nx = sat_inc(dcnt);
                end
            end
            RUN: begin
                // A lost request (command change or end switch) outranks the
                // timeout on the same edge.
                if (!tgt_req) begin
                    state_nx = BRAKE;
                    dcnt_nx  = '0;
                end else if (rcnt == RUN_LAST) begin
                    state_nx = FAULT;
                end else begin
                    rcnt_nx = sat_inc(rcnt);
                end
            end
            BRAKE: begin
                if (dcnt == DEAD_LAST) begin
                    state_nx = IDLE;
                end else begin
                    dcnt_nx = sat_inc(dcnt);
                end
            end
            FAULT: begin
                if (bus.fault_clr) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Direction follows the target while starting or running, and otherwise
    // holds its last value so it never moves during the brake phase.
    always_comb begin
        motor_en_nx  = (state_nx == RUN);
        fault_nx     = (state_nx == FAULT);
        busy_nx      = (state_nx != IDLE);
        motor_dir_nx = motor_dir_q;
        if (state_nx == DEAD || state_nx == RUN) begin
            motor_dir_nx = tgt_nx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: every register, including the counters, is cleared by the async
    // reset, so motor_en drops the moment reset asserts, without a clock.
    always_ff @(posedge Reloj or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tgt         <= 1'b0;
            dcnt        <= '0;
            rcnt        <= '0;
            motor_en_q  <= 1'b0;
            motor_dir_q <= 1'b0;
            fault_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            tgt         <= tgt_nx;
            dcnt        <= dcnt_nx;
            rcnt        <= rcnt_nx;
            motor_en_q  <= motor_en_nx;
            motor_dir_q <= motor_dir_nx;
            fault_q     <= fault_nx;
            busy_q      <= busy_nx;
        end
    end

    assign bus.motor_en  = motor_en_q;
    assign bus.motor_dir = motor_dir_q;
    assign bus.fault     = fault_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_persiana_motor_driver.sv
// tb_persiana_motor_driver
//   Directed bench for persiana_motor_driver with DEAD_T=4, MAX_RUN=16.
//   A table of single-edge vectors covers start timing, stop/brake timing and
//   blocked requests; hand-written sequences cover end-switch stop, reversal,
//   run timeout with fault clear, and asynchronous reset mid-run.
module tb_persiana_motor_driver;

    localparam int DEAD_T  = 4;
    localparam int MAX_RUN = 16;
    localparam int TW      = 11;

    logic Reloj;
    logic reset;

    persiana_motor_driver_if bus ();

    persiana_motor_driver #(
        .DEAD_T (DEAD_T),
        .MAX_RUN(MAX_RUN),
        .TW     (TW)
    ) dut (
        .Reloj(Reloj),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial Reloj = 1'b0;
    always #5 Reloj = ~Reloj;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One rising edge, then settle just past it before anything is sampled.
    task automatic tick();
        @(posedge Reloj);
        #1;
    endtask

    task automatic drive(input logic [4:0] v);
        {bus.subir, bus.bajar, bus.Ssup, bus.Sinf, bus.fault_clr} = v;
    endtask

    task automatic go_idle();
        drive(5'b00000);
        repeat (12) tick();
    endtask

    // in  = {subir, bajar, Ssup, Sinf, fault_clr}
    // exp = {motor_en, motor_dir, fault, busy} after the edge
    typedef struct {
        logic [4:0] in;
        logic [3:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] in, input logic [3:0] exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        return v;
    endfunction

    vec_t vecs[17];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int on_cnt;
        int off_cnt;
        int drop_cnt;
        logic seen;
        logic got_fault;

        // Start-up timing: request at edge 0, DEAD after edges 0..3, RUN after 4.
        vecs[0]  = mk(5'b10000, 4'b0101);
        vecs[1]  = mk(5'b10000, 4'b0101);
        vecs[2]  = mk(5'b10000, 4'b0101);
        vecs[3]  = mk(5'b10000, 4'b0101);
        vecs[4]  = mk(5'b10000, 4'b1101);
        vecs[5]  = mk(5'b10000, 4'b1101);
        // Drop subir: motor off at once, busy lasts exactly 4 more edges.
        vecs[6]  = mk(5'b00000, 4'b0101);
        vecs[7]  = mk(5'b00000, 4'b0101);
        vecs[8]  = mk(5'b00000, 4'b0101);
        vecs[9]  = mk(5'b00000, 4'b0101);
        vecs[10] = mk(5'b00000, 4'b0100);
        // Illegal / blocked requests never leave IDLE.
        vecs[11] = mk(5'b11000, 4'b0100);
        vecs[12] = mk(5'b01010, 4'b0100);
        vecs[13] = mk(5'b10100, 4'b0100);
        // Down request enters DEAD with dir settled low, then is withdrawn.
        vecs[14] = mk(5'b01000, 4'b0001);
        vecs[15] = mk(5'b00000, 4'b0000);
        // fault_clr outside FAULT has no effect.
        vecs[16] = mk(5'b00001, 4'b0000);

        reset = 1'b0;
        drive(5'b00000);
        repeat (2) tick();
        check("reset_en",    32'(bus.motor_en),  32'd0);
        check("reset_dir",   32'(bus.motor_dir), 32'd0);
        check("reset_fault", 32'(bus.fault),     32'd0);
        check("reset_busy",  32'(bus.busy),      32'd0);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].in);
            tick();
            check($sformatf("v%0d_en", i),    32'(bus.motor_en),  32'(vecs[i].exp[3]));
            check($sformatf("v%0d_dir", i),   32'(bus.motor_dir), 32'(vecs[i].exp[2]));
            check($sformatf("v%0d_fault", i), 32'(bus.fault),     32'(vecs[i].exp[1]));
            check($sformatf("v%0d_busy", i),  32'(bus.busy),      32'(vecs[i].exp[0]));
        end

        // End switch stop while running up; no restart while Ssup stays high.
        go_idle();
        drive(5'b10000);
        repeat (5) tick();
        check("t3_run_en",  32'(bus.motor_en),  32'd1);
        check("t3_run_dir", 32'(bus.motor_dir), 32'd1);
        drive(5'b10100);
        tick();
        check("t3_stop_en", 32'(bus.motor_en), 32'd0);
        on_cnt = 0;
        repeat (20) begin
            tick();
            if (bus.motor_en) on_cnt++;
        end
        check("t3_no_restart", 32'(on_cnt),   32'd0);
        check("t3_idle_busy",  32'(bus.busy), 32'd0);

        // Reversal from down to up: 2*DEAD_T+1 off cycles, then up.
        go_idle();
        drive(5'b01000);
        repeat (5) tick();
        check("t4_run_en",  32'(bus.motor_en),  32'd1);
        check("t4_run_dir", 32'(bus.motor_dir), 32'd0);
        drive(5'b10000);
        off_cnt = 0;
        seen    = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.motor_en) begin
                seen = 1'b1;
                break;
            end
            off_cnt++;
        end
        check("t4_restarted", 32'(seen),          32'd1);
        check("t4_off_cycles", 32'(off_cnt),      32'd9);
        check("t4_new_dir",   32'(bus.motor_dir), 32'd1);

        // Run timeout: exactly MAX_RUN on-cycles, then a sticky fault.
        go_idle();
        drive(5'b01000);
        on_cnt    = 0;
        drop_cnt  = 0;
        got_fault = 1'b0;
        repeat (40) begin
            tick();
            if (bus.motor_en) on_cnt++;
            if (bus.fault) got_fault = 1'b1;
            else if (got_fault) drop_cnt++;
        end
        check("t5_on_cycles",  32'(on_cnt),        32'd16);
        check("t5_fault",      32'(bus.fault),     32'd1);
        check("t5_fault_held", 32'(drop_cnt),      32'd0);
        check("t5_fault_busy", 32'(bus.busy),      32'd1);
        check("t5_fault_en",   32'(bus.motor_en),  32'd0);
        drive(5'b00001);
        tick();
        check("t5_clr_fault", 32'(bus.fault), 32'd0);
        check("t5_clr_busy",  32'(bus.busy),  32'd0);
        drive(5'b00000);

        // Async reset between edges while running, then subir&bajar from IDLE.
        go_idle();
        drive(5'b10000);
        repeat (5) tick();
        check("t6_run_en", 32'(bus.motor_en), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        check("t6_async_en",    32'(bus.motor_en),  32'd0);
        check("t6_async_busy",  32'(bus.busy),      32'd0);
        check("t6_async_dir",   32'(bus.motor_dir), 32'd0);
        #2;
        reset = 1'b1;
        drive(5'b11000);
        on_cnt = 0;
        repeat (10) begin
            tick();
            if (bus.motor_en) on_cnt++;
        end
        check("t6_both_no_start", 32'(on_cnt),   32'd0);
        check("t6_both_busy",     32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
